// File: rtl/int_ctrl_if.sv
// ============================================================================
//  Module      : int_ctrl_if
//  Description : Bus between the CPU core and the interrupt controller:
//                SFR contents, source flags, core handshake, request/vector
//                and hardware flag-clear pulses. Timer-2 flags exist only
//                when INT_TIMER2_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface int_ctrl_if;
    logic [7:0] IE_data;
    logic [7:0] IP_data;
    logic       ie0;
    logic       tf0;
    logic       ie1;
    logic       tf1;
    logic       ri;
    logic       ti;
    logic       it0;
    logic       it1;
`ifdef INT_TIMER2_EN
    logic       tf2;
    logic       exf2;
`endif
    logic       int_block;
    logic       int_ack;
    logic       reti;
    logic       int_req;
    logic [7:0] int_vect;
    logic       clr_ie0;
    logic       clr_tf0;
    logic       clr_ie1;
    logic       clr_tf1;

`ifdef INT_TIMER2_EN
    modport master (
        output IE_data, IP_data, ie0, tf0, ie1, tf1, ri, ti, it0, it1,
               tf2, exf2, int_block, int_ack, reti,
        input  int_req, int_vect, clr_ie0, clr_tf0, clr_ie1, clr_tf1
    );
    modport slave (
        input  IE_data, IP_data, ie0, tf0, ie1, tf1, ri, ti, it0, it1,
               tf2, exf2, int_block, int_ack, reti,
        output int_req, int_vect, clr_ie0, clr_tf0, clr_ie1, clr_tf1
    );
`else
    modport master (
        output IE_data, IP_data, ie0, tf0, ie1, tf1, ri, ti, it0, it1,
               int_block, int_ack, reti,
        input  int_req, int_vect, clr_ie0, clr_tf0, clr_ie1, clr_tf1
    );
    modport slave (
        input  IE_data, IP_data, ie0, tf0, ie1, tf1, ri, ti, it0, it1,
               int_block, int_ack, reti,
        output int_req, int_vect, clr_ie0, clr_tf0, clr_ie1, clr_tf1
    );
`endif
endinterface

`default_nettype wire

// File: rtl/int_ctrl.sv
// ============================================================================
//  Module      : int_ctrl
//  Description : 8051-style two-level interrupt controller. Arbitrates the
//                enabled sources by priority level and fixed polling order,
//                holds one request towards the core until acknowledged or
//                withdrawn, tracks in-service levels and pulses hardware
//                flag clears. Optional macro INT_TIMER2_EN adds the Timer-2
//                source (tf2|exf2, IE[5]/IP[5], vector 0x2B).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_ctrl (
    input  wire logic  clock,
    input  wire logic  reset,
    int_ctrl_if.slave  bus
);

    localparam int         NSRC   = 6;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    logic            r_isr_hi;
    logic            r_isr_lo;
    logic            w_isr_hi_next;
    logic            w_isr_lo_next;
    logic [2:0]      r_idx;
    logic            r_lvl;
    logic [7:0]      r_vect;
    logic [3:0]      r_clr;
    logic [NSRC-1:0] w_flag;
    logic [NSRC-1:0] w_en;
    logic [NSRC-1:0] w_pri;
    logic [7:0]      w_elig;
    logic            w_found;
    logic [2:0]      w_win_idx;
    logic            w_win_lvl;
    logic            w_take_req;
    logic            w_take_ack;
    logic            w_unused;

    // Per-source flag, enable and priority in polling order (bit 0 polled first)
    always_comb begin
        w_flag = {1'b0, bus.ri | bus.ti, bus.tf1, bus.ie1, bus.tf0, bus.ie0};
        w_en   = {1'b0, bus.IE_data[4:0]};
        w_pri  = {1'b0, bus.IP_data[4:0]};
`ifdef INT_TIMER2_EN
        w_flag[5] = bus.tf2 | bus.exf2;
        w_en[5]   = bus.IE_data[5];
        w_pri[5]  = bus.IP_data[5];
`endif
    end

`ifdef INT_TIMER2_EN
    assign w_unused = ^{bus.IE_data[6], bus.IP_data[7:6]};
`else
    assign w_unused = ^{bus.IE_data[6:5], bus.IP_data[7:5]};
`endif

    // A source is eligible only if its level is above the level in service
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (!bus.IE_data[7] || r_isr_hi)
                w_elig[i] = 1'b0;
            else if (r_isr_lo)
                w_elig[i] = w_en[i] & w_flag[i] & w_pri[i];
            else
                w_elig[i] = w_en[i] & w_flag[i];
        end
    end

    // Winner: any high-level source beats any low one; lowest index wins a tie
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = 3'd0;
        w_win_lvl = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_elig[i] && !w_pri[i]) begin
                w_found   = 1'b1;
                w_win_idx = 3'(i);
            end
        end
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_elig[i] && w_pri[i]) begin
                w_found   = 1'b1;
                w_win_idx = 3'(i);
                w_win_lvl = 1'b1;
            end
        end
    end

    assign w_take_req = (r_state == S_IDLE) && w_found && !bus.int_block;
    assign w_take_ack = (r_state == S_REQ) && bus.int_ack;

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next state: ack wins over withdraw; no re-arbitration while requesting
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_take_req) w_state_next = S_REQ;
            S_REQ:   if (bus.int_ack || !w_elig[r_idx]) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs: request and vector are visible only while requesting
    always_comb begin
        bus.int_req  = (r_state == S_REQ);
        bus.int_vect = (r_state == S_REQ) ? r_vect : 8'h00;
        bus.clr_ie0  = r_clr[0];
        bus.clr_tf0  = r_clr[1];
        bus.clr_ie1  = r_clr[2];
        bus.clr_tf1  = r_clr[3];
    end

    // Latch the winner's index, level and vector (8*idx + 3) on request entry
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx  <= 3'd0;
            r_lvl  <= 1'b0;
            r_vect <= 8'h00;
        end else if (w_take_req) begin
            r_idx  <= w_win_idx;
            r_lvl  <= w_win_lvl;
            r_vect <= {2'b00, w_win_idx, 3'b011};
        end
    end

    // In-service update: RETI clears the top level first, then ack sets latched level
    always_comb begin
        w_isr_hi_next = r_isr_hi;
        w_isr_lo_next = r_isr_lo;
        if (bus.reti) begin
            if (r_isr_hi)
                w_isr_hi_next = 1'b0;
            else
                w_isr_lo_next = 1'b0;
        end
        if (w_take_ack) begin
            if (r_lvl)
                w_isr_hi_next = 1'b1;
            else
                w_isr_lo_next = 1'b1;
        end
    end

    // In-service registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_isr_hi <= 1'b0;
            r_isr_lo <= 1'b0;
        end else begin
            r_isr_hi <= w_isr_hi_next;
            r_isr_lo <= w_isr_lo_next;
        end
    end

    // One-cycle flag clears; level-triggered externals, serial and TF2 stay to software
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clr <= 4'b0000;
        end else if (w_take_ack) begin
            r_clr <= {r_idx == 3'd3,
                      (r_idx == 3'd2) & bus.it1,
                      r_idx == 3'd1,
                      (r_idx == 3'd0) & bus.it0};
        end else begin
            r_clr <= 4'b0000;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// ============================================================================
//  Module      : tb_int_ctrl
//  Description : Self-checking bench for int_ctrl. A behavioural model
//                (in-service stack, scored arbitration) predicts each cycle's
//                outputs into a queue; a monitor compares every cycle.
//                Directed scenarios plus randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_int_ctrl;

    logic clock = 1'b0;
    logic reset;

    int_ctrl_if bus();

    int_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic       req;
        logic [7:0] vect;
        logic [3:0] clr;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int   m_pend = -1;      // source index being requested, -1 = none
    bit   m_pend_hi;
    bit   m_stack[$];       // levels in service, 1 = high

    function automatic bit src_flag(int i);
        case (i)
            0: return bus.ie0;
            1: return bus.tf0;
            2: return bus.ie1;
            3: return bus.tf1;
            4: return bus.ri | bus.ti;
`ifdef INT_TIMER2_EN
            5: return bus.tf2 | bus.exf2;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic int active_level();
        int a = 0;
        foreach (m_stack[k]) a = (m_stack[k] ? 2 : 1) > a ? (m_stack[k] ? 2 : 1) : a;
        return a;
    endfunction

    function automatic bit elig(int i);
        int lvl = bus.IP_data[i] ? 2 : 1;
        return bus.IE_data[7] && bus.IE_data[i] && src_flag(i) && (lvl > active_level());
    endfunction

    function automatic int pick();
        int best = -1;
        int best_score = -1;
        for (int i = 0; i < 6; i++) begin
            if (elig(i)) begin
                int score = (bus.IP_data[i] ? 100 : 0) + (10 - i);
                if (score > best_score) begin
                    best_score = score;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    // Predict what the DUT shows after the coming clock edge
    task automatic model_step();
        exp_t     e;
        bit [3:0] nc = 4'b0000;
        bit       acked = 1'b0;
        int       w;
        if (reset) begin
            m_pend = -1;
            m_stack.delete();
        end else begin
            if (m_pend < 0) begin
                if (!bus.int_block) begin
                    w = pick();
                    if (w >= 0) begin
                        m_pend    = w;
                        m_pend_hi = bus.IP_data[w];
                    end
                end
            end else if (bus.int_ack) begin
                acked = 1'b1;
                case (m_pend)
                    0: nc[0] = bus.it0;
                    1: nc[1] = 1'b1;
                    2: nc[2] = bus.it1;
                    3: nc[3] = 1'b1;
                    default: nc = 4'b0000;
                endcase
            end else if (!elig(m_pend)) begin
                m_pend = -1;
            end
            if (bus.reti && m_stack.size() > 0) void'(m_stack.pop_back());
            if (acked) begin
                m_stack.push_back(m_pend_hi);
                m_pend = -1;
            end
        end
        e.cyc  = cyc + 1;
        e.req  = (m_pend >= 0);
        e.vect = (m_pend >= 0) ? 8'(3 + 8 * m_pend) : 8'h00;
        e.clr  = nc;
        if (e.req || e.clr != 4'b0000) sbq.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] clr_bits();
        return {4'b0000, bus.clr_tf1, bus.clr_ie1, bus.clr_tf0, bus.clr_ie0};
    endfunction

    task automatic clear_inputs();
        bus.IE_data = 8'h00; bus.IP_data = 8'h00;
        bus.ie0 = 0; bus.tf0 = 0; bus.ie1 = 0; bus.tf1 = 0;
        bus.ri = 0; bus.ti = 0; bus.it0 = 0; bus.it1 = 0;
`ifdef INT_TIMER2_EN
        bus.tf2 = 0; bus.exf2 = 0;
`endif
        bus.int_block = 0; bus.int_ack = 0; bus.reti = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Monitor: every cycle compare outputs with the queued prediction (or idle)
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (cyc >= 1) begin
                e.cyc = cyc; e.req = 1'b0; e.vect = 8'h00; e.clr = 4'b0000;
                if (sbq.size() > 0 && sbq[0].cyc == cyc) e = sbq.pop_front();
                checks++;
                if (bus.int_req !== e.req || bus.int_vect !== e.vect ||
                    clr_bits() !== {4'b0000, e.clr}) begin
                    errors++;
                    $display("FAIL cycle %0d outputs: got req=%b vect=%h clr=%b expected req=%b vect=%h clr=%b",
                             cyc, bus.int_req, bus.int_vect, clr_bits(), e.req, e.vect, e.clr);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        clear_inputs();

        // Reset state
        do_reset();
        chk("reset_req", {7'd0, bus.int_req}, 8'h00);
        chk("reset_vect", bus.int_vect, 8'h00);
        chk("reset_clr", clr_bits(), 8'h00);

        // Edge-triggered INT0, low level
        bus.IE_data = 8'h81;
        tick(); tick(); tick();
        chk("ex0_quiet", {7'd0, bus.int_req}, 8'h00);
        bus.ie0 = 1; bus.it0 = 1;
        tick();
        chk("ex0_req", {7'd0, bus.int_req}, 8'h01);
        chk("ex0_vect", bus.int_vect, 8'h03);
        bus.int_ack = 1;
        tick();
        chk("ex0_clr", clr_bits(), 8'h01);
        chk("ex0_req_drop", {7'd0, bus.int_req}, 8'h00);
        bus.int_ack = 0;
        tick(); tick();
        chk("ex0_blocked_by_isr_lo", {7'd0, bus.int_req}, 8'h00);
        bus.reti = 1; tick(); bus.reti = 0; tick();
        chk("ex0_after_reti", bus.int_vect, 8'h03);

        // High priority beats polling order
        do_reset();
        bus.IE_data = 8'h8A; bus.IP_data = 8'h08;
        bus.tf0 = 1; bus.tf1 = 1;
        tick();
        chk("hi_wins_vect", bus.int_vect, 8'h1B);
        bus.int_ack = 1; tick();
        chk("tf1_clr", clr_bits(), 8'h08);
        bus.int_ack = 0; bus.tf1 = 0;
        tick(); tick();
        chk("tf0_blocked_by_isr_hi", {7'd0, bus.int_req}, 8'h00);
        bus.reti = 1; tick(); bus.reti = 0; tick();
        chk("tf0_after_reti", bus.int_vect, 8'h0B);

        // Preemption of low by high; level INT1 gets no clear; two RETIs
        do_reset();
        bus.IE_data = 8'h86;
        bus.tf0 = 1; tick();
        bus.int_ack = 1; tick();
        bus.int_ack = 0; bus.tf0 = 0;
        bus.IP_data = 8'h04; bus.ie1 = 1; bus.it1 = 0;
        tick();
        chk("preempt_vect", bus.int_vect, 8'h13);
        bus.int_ack = 1; tick();
        chk("ie1_level_no_clr", clr_bits(), 8'h00);
        bus.int_ack = 0; bus.ie1 = 0; tick();
        bus.reti = 1; tick(); bus.reti = 0; tick();
        bus.reti = 1; tick(); bus.reti = 0;
        bus.IP_data = 8'h00; bus.tf0 = 1;
        tick();
        chk("isr_empty_after_two_reti", bus.int_vect, 8'h0B);

        // Withdraw on EA clear, then int_block holds off a new request
        do_reset();
        bus.IE_data = 8'h90; bus.ri = 1;
        tick();
        chk("serial_vect", bus.int_vect, 8'h23);
        bus.IE_data = 8'h10; tick();
        chk("withdraw", {7'd0, bus.int_req}, 8'h00);
        bus.IE_data = 8'h90; bus.int_block = 1;
        tick(); tick();
        chk("int_block", {7'd0, bus.int_req}, 8'h00);
        bus.int_block = 0; tick();
        chk("serial_again", bus.int_vect, 8'h23);
        bus.int_ack = 1; tick();
        chk("serial_no_clr", clr_bits(), 8'h00);
        bus.int_ack = 0; bus.ri = 0;

`ifdef INT_TIMER2_EN
        do_reset();
        bus.IE_data = 8'hA0; bus.exf2 = 1;
        tick();
        chk("tf2_vect", bus.int_vect, 8'h2B);
        bus.int_ack = 1; tick();
        chk("tf2_no_clr", clr_bits(), 8'h00);
        bus.int_ack = 0; bus.exf2 = 0;
`else
        do_reset();
        bus.IE_data = 8'hA0; bus.IP_data = 8'h20;
        tick(); tick();
        chk("no_tf2_source", {7'd0, bus.int_req}, 8'h00);
`endif

        // Reset asserted while requesting overrides ack and reti
        do_reset();
        bus.IE_data = 8'h90; bus.ti = 1;
        tick();
        chk("pre_reset_req", {7'd0, bus.int_req}, 8'h01);
        reset = 1; bus.int_ack = 1; bus.reti = 1;
        tick();
        chk("reset_in_req_req", {7'd0, bus.int_req}, 8'h00);
        chk("reset_in_req_vect", bus.int_vect, 8'h00);
        reset = 0; bus.int_ack = 0; bus.reti = 0;
        tick();

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) bus.IE_data = 8'($urandom);
            if ($urandom_range(0, 9) != 0) bus.IE_data[7] = 1'b1;
            if ($urandom_range(0, 9) == 0) bus.IP_data = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bus.ie0 = ~bus.ie0;
            if ($urandom_range(0, 7) == 0) bus.tf0 = ~bus.tf0;
            if ($urandom_range(0, 7) == 0) bus.ie1 = ~bus.ie1;
            if ($urandom_range(0, 7) == 0) bus.tf1 = ~bus.tf1;
            if ($urandom_range(0, 9) == 0) bus.ri = ~bus.ri;
            if ($urandom_range(0, 9) == 0) bus.ti = ~bus.ti;
`ifdef INT_TIMER2_EN
            if ($urandom_range(0, 9) == 0) bus.tf2 = ~bus.tf2;
            if ($urandom_range(0, 9) == 0) bus.exf2 = ~bus.exf2;
`endif
            if ($urandom_range(0, 15) == 0) bus.it0 = ~bus.it0;
            if ($urandom_range(0, 15) == 0) bus.it1 = ~bus.it1;
            bus.int_block = ($urandom_range(0, 5) == 0);
            bus.int_ack   = (m_pend >= 0) ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 9) == 0);
            bus.reti      = ($urandom_range(0, 11) == 0);
            reset         = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 0;
        clear_inputs();

        @(negedge clock);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
